// File: rtl/hms_pkg.sv
// Shared widths, limits, ring FSM encoding and wrap-increment helper for hms_timekeeper.
package hms_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic {
        StIdle,
        StRing
    } ring_state_e;

    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
        return (val == max) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/tick_edge.sv
// Samples one tick input into clk and emits a one-cycle pulse on each rising edge.
// HMS_TICK_SYNC_EN selects a 2-flop synchronizer instead of a single sampling flop.
module tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic tick_o
);

    logic samp_q;
    logic prev_q;

`ifdef HMS_TICK_SYNC_EN
    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            samp_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= level_i;
            samp_q <= meta_q;
            prev_q <= samp_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            samp_q <= level_i;
            prev_q <= samp_q;
        end
    end
`endif

    assign tick_o = samp_q & ~prev_q;

endmodule

// File: rtl/hms_timekeeper.sv
// Time-of-day and alarm counters driven by external tick inputs, with wrap pulses and alarm ring.
// Tick sampling depth is selected by HMS_TICK_SYNC_EN inside tick_edge.
module hms_timekeeper
    import hms_pkg::*;
#(
    parameter int unsigned RING_SEC = 10,
    parameter int unsigned HOUR_MOD = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sec_clk,
    input  logic              i_min_clk,
    input  logic              i_hour_clk,
    input  logic              i_alarm_sec_clk,
    input  logic              i_alarm_min_clk,
    input  logic              i_alarm_hour_clk,
    input  logic              i_alarm_en,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic [SEC_W-1:0]  o_alarm_sec,
    output logic [MIN_W-1:0]  o_alarm_min,
    output logic [HOUR_W-1:0] o_alarm_hour,
    output logic              o_max_hit_sec,
    output logic              o_max_hit_min,
    output logic              o_max_hit_hour,
    output logic              o_alarm_ring
);

    localparam logic [HOUR_W-1:0] HourMax  = HOUR_W'(HOUR_MOD - 1);
    localparam logic [5:0]        RingLoad = 6'(RING_SEC);

    logic tick_sec, tick_min, tick_hour;
    logic tick_asec, tick_amin, tick_ahour;

    tick_edge u_sec   (.clk(clk), .rst(rst), .level_i(i_sec_clk),        .tick_o(tick_sec));
    tick_edge u_min   (.clk(clk), .rst(rst), .level_i(i_min_clk),        .tick_o(tick_min));
    tick_edge u_hour  (.clk(clk), .rst(rst), .level_i(i_hour_clk),       .tick_o(tick_hour));
    tick_edge u_asec  (.clk(clk), .rst(rst), .level_i(i_alarm_sec_clk),  .tick_o(tick_asec));
    tick_edge u_amin  (.clk(clk), .rst(rst), .level_i(i_alarm_min_clk),  .tick_o(tick_amin));
    tick_edge u_ahour (.clk(clk), .rst(rst), .level_i(i_alarm_hour_clk), .tick_o(tick_ahour));

    logic [SEC_W-1:0]  sec_q, sec_d, asec_q, asec_d;
    logic [MIN_W-1:0]  min_q, min_d, amin_q, amin_d;
    logic [HOUR_W-1:0] hour_q, hour_d, ahour_q, ahour_d;
    logic              hit_sec_q, hit_sec_d;
    logic              hit_min_q, hit_min_d;
    logic              hit_hour_q, hit_hour_d;
    logic              match, match_q, trigger;

    always_comb begin
        sec_d   = tick_sec  ? wrap_inc(sec_q, SEC_MAX)  : sec_q;
        min_d   = tick_min  ? wrap_inc(min_q, MIN_MAX)  : min_q;
        asec_d  = tick_asec ? wrap_inc(asec_q, SEC_MAX) : asec_q;
        amin_d  = tick_amin ? wrap_inc(amin_q, MIN_MAX) : amin_q;
        hour_d  = hour_q;
        ahour_d = ahour_q;
        if (tick_hour) begin
            hour_d = (hour_q == HourMax) ? '0 : hour_q + 1'b1;
        end
        if (tick_ahour) begin
            ahour_d = (ahour_q == HourMax) ? '0 : ahour_q + 1'b1;
        end
        // Pulse is registered alongside the wrap so it lines up with the counter showing 0.
        hit_sec_d  = tick_sec  && (sec_q == SEC_MAX);
        hit_min_d  = tick_min  && (min_q == MIN_MAX);
        hit_hour_d = tick_hour && (hour_q == HourMax);
    end

    assign match   = (sec_q == asec_q) && (min_q == amin_q) && (hour_q == ahour_q);
    assign trigger = i_alarm_en & match & ~match_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            asec_q     <= '0;
            amin_q     <= '0;
            ahour_q    <= '0;
            hit_sec_q  <= 1'b0;
            hit_min_q  <= 1'b0;
            hit_hour_q <= 1'b0;
            // Starts high so the all-zero time/alarm pair after reset does not ring.
            match_q    <= 1'b1;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            asec_q     <= asec_d;
            amin_q     <= amin_d;
            ahour_q    <= ahour_d;
            hit_sec_q  <= hit_sec_d;
            hit_min_q  <= hit_min_d;
            hit_hour_q <= hit_hour_d;
            match_q    <= match;
        end
    end

    ring_state_e state_q;
    logic [5:0]  ring_cnt_q;
    logic        ring_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ring_cnt_q <= '0;
            ring_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_q    <= StRing;
                        ring_cnt_q <= RingLoad;
                        ring_q     <= 1'b1;
                    end
                end
                StRing: begin
                    if (!i_alarm_en) begin
                        state_q    <= StIdle;
                        ring_cnt_q <= '0;
                        ring_q     <= 1'b0;
                    end else if (trigger) begin
                        ring_cnt_q <= RingLoad;
                    end else if (tick_sec) begin
                        if (ring_cnt_q <= 6'd1) begin
                            state_q    <= StIdle;
                            ring_cnt_q <= '0;
                            ring_q     <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q - 6'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    ring_cnt_q <= '0;
                    ring_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_sec          = sec_q;
    assign o_min          = min_q;
    assign o_hour         = hour_q;
    assign o_alarm_sec    = asec_q;
    assign o_alarm_min    = amin_q;
    assign o_alarm_hour   = ahour_q;
    assign o_max_hit_sec  = hit_sec_q;
    assign o_max_hit_min  = hit_min_q;
    assign o_max_hit_hour = hit_hour_q;
    assign o_alarm_ring   = ring_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed self-checking bench for hms_timekeeper (24-hour instance plus a 12-hour instance).
module tb_hms_timekeeper;

    localparam int TSec   = 0;
    localparam int TMin   = 1;
    localparam int THour  = 2;
    localparam int TASec  = 3;
    localparam int TAMin  = 4;
    localparam int TAHour = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sec_drv = 1'b0, min_drv = 1'b0, hour_drv = 1'b0;
    logic asec_drv = 1'b0, amin_drv = 1'b0, ahour_drv = 1'b0;
    logic alarm_en = 1'b0;
    logic loop_en = 1'b0;
    logic min_in;

    logic [5:0] o_sec, o_min, o_alarm_sec, o_alarm_min;
    logic [4:0] o_hour, o_alarm_hour;
    logic       o_max_hit_sec, o_max_hit_min, o_max_hit_hour, o_alarm_ring;

    logic [5:0] s12, m12, as12, am12;
    logic [4:0] h12, ah12;
    logic       hs12, hm12, hh12, ring12;

    int total = 0;
    int bad   = 0;
    int hs_n, hm_n, hh_n, hh12_n, ring_n;

    always #10 clk = ~clk;

    assign min_in = loop_en ? o_max_hit_sec : min_drv;

    hms_timekeeper #(.RING_SEC(10), .HOUR_MOD(24)) dut (
        .clk(clk), .rst(rst),
        .i_sec_clk(sec_drv), .i_min_clk(min_in), .i_hour_clk(hour_drv),
        .i_alarm_sec_clk(asec_drv), .i_alarm_min_clk(amin_drv), .i_alarm_hour_clk(ahour_drv),
        .i_alarm_en(alarm_en),
        .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_alarm_sec(o_alarm_sec), .o_alarm_min(o_alarm_min), .o_alarm_hour(o_alarm_hour),
        .o_max_hit_sec(o_max_hit_sec), .o_max_hit_min(o_max_hit_min),
        .o_max_hit_hour(o_max_hit_hour), .o_alarm_ring(o_alarm_ring)
    );

    hms_timekeeper #(.RING_SEC(10), .HOUR_MOD(12)) dut12 (
        .clk(clk), .rst(rst),
        .i_sec_clk(sec_drv), .i_min_clk(min_in), .i_hour_clk(hour_drv),
        .i_alarm_sec_clk(asec_drv), .i_alarm_min_clk(amin_drv), .i_alarm_hour_clk(ahour_drv),
        .i_alarm_en(alarm_en),
        .o_sec(s12), .o_min(m12), .o_hour(h12),
        .o_alarm_sec(as12), .o_alarm_min(am12), .o_alarm_hour(ah12),
        .o_max_hit_sec(hs12), .o_max_hit_min(hm12),
        .o_max_hit_hour(hh12), .o_alarm_ring(ring12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        hs_n = 0; hm_n = 0; hh_n = 0; hh12_n = 0; ring_n = 0;
    endtask

    // Advances n cycles, sampling on the falling edge and tallying pulse/ring cycles.
    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs_n   += int'(o_max_hit_sec);
            hm_n   += int'(o_max_hit_min);
            hh_n   += int'(o_max_hit_hour);
            hh12_n += int'(hh12);
            ring_n += int'(o_alarm_ring);
        end
    endtask

    task automatic set_tick(input int which, input logic v);
        case (which)
            TSec:    sec_drv   = v;
            TMin:    min_drv   = v;
            THour:   hour_drv  = v;
            TASec:   asec_drv  = v;
            TAMin:   amin_drv  = v;
            default: ahour_drv = v;
        endcase
    endtask

    task automatic tick(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            set_tick(which, 1'b1);
            wait_cyc(5);
            set_tick(which, 1'b0);
            wait_cyc(3);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        int found;
        clr_counts();
        do_reset();

        // Reset state
        chk("rst_sec", o_sec, 0);
        chk("rst_min", o_min, 0);
        chk("rst_hour", o_hour, 0);
        chk("rst_alarm_sec", o_alarm_sec, 0);
        chk("rst_ring", o_alarm_ring, 0);

        // Three second ticks
        clr_counts();
        tick(TSec, 3);
        chk("sec3", o_sec, 3);
        chk("sec3_min", o_min, 0);
        chk("sec3_hour", o_hour, 0);
        chk("sec3_hits", hs_n + hm_n + hh_n, 0);
        chk("sec3_ring", ring_n, 0);

        // Seconds wrap with loopback into minute tick
        tick(TSec, 56);
        chk("sec59", o_sec, 59);
        chk("sec59_min_no_cascade", o_min, 0);
        loop_en = 1'b1;
        clr_counts();
        tick(TSec, 1);
        wait_cyc(4);
        loop_en = 1'b0;
        chk("sec_wrap", o_sec, 0);
        chk("sec_hit_width", hs_n, 1);
        chk("loop_min", o_min, 1);
        chk("loop_min_no_hit", hm_n, 0);

        // Hour wrap, 24 and 12
        do_reset();
        clr_counts();
        tick(THour, 11);
        chk("h12_at11", h12, 11);
        tick(THour, 1);
        chk("h12_wrap", h12, 0);
        chk("h12_hit", hh12_n, 1);
        chk("h24_at12", o_hour, 12);
        chk("h24_no_hit", hh_n, 0);
        tick(THour, 11);
        chk("h24_at23", o_hour, 23);
        clr_counts();
        tick(THour, 1);
        chk("h24_wrap", o_hour, 0);
        chk("h24_hit", hh_n, 1);

        // Alarm 00:01:05 rings for 10 second ticks
        do_reset();
        tick(TASec, 5);
        tick(TAMin, 1);
        chk("alarm_sec_set", o_alarm_sec, 5);
        chk("alarm_min_set", o_alarm_min, 1);
        chk("alarm_no_hit", hs_n + hm_n, 0);
        alarm_en = 1'b1;
        tick(TMin, 1);
        tick(TSec, 4);
        @(negedge clk);
        sec_drv = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (o_sec == 6'd5) found = 1;
        end
        chk("match_reached", found, 1);
        chk("ring_not_yet", o_alarm_ring, 0);
        @(negedge clk);
        chk("ring_rise", o_alarm_ring, 1);
        sec_drv = 1'b0;
        wait_cyc(3);
        tick(TSec, 9);
        chk("ring_after9", o_alarm_ring, 1);
        tick(TSec, 1);
        chk("ring_after10", o_alarm_ring, 0);

        // Same alarm with enable low
        alarm_en = 1'b0;
        do_reset();
        tick(TASec, 5);
        tick(TAMin, 1);
        clr_counts();
        tick(TMin, 1);
        tick(TSec, 5);
        chk("noen_sec", o_sec, 5);
        chk("noen_ring", ring_n, 0);

        // Editing alarm onto time triggers; dropping enable stops ring
        do_reset();
        alarm_en = 1'b1;
        tick(TSec, 1);
        tick(TASec, 1);
        chk("edit_ring", o_alarm_ring, 1);
        alarm_en = 1'b0;
        @(negedge clk);
        chk("en_drop", o_alarm_ring, 0);
        alarm_en = 1'b1;
        clr_counts();
        wait_cyc(5);
        chk("no_retrigger", ring_n, 0);

        // Reset mid-ring
        tick(TASec, 1);
        tick(TSec, 1);
        chk("ring_again", o_alarm_ring, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ring", o_alarm_ring, 0);
        chk("midrst_sec", o_sec, 0);
        chk("midrst_asec", o_alarm_sec, 0);
        chk("midrst_hits", {o_max_hit_sec, o_max_hit_min, o_max_hit_hour}, 0);
        rst = 1'b0;
        clr_counts();
        wait_cyc(20);
        chk("postrst_ring", ring_n, 0);
        alarm_en = 1'b0;

        // Held level gives one tick; simultaneous ticks
        do_reset();
        sec_drv = 1'b1;
        wait_cyc(100);
        sec_drv = 1'b0;
        wait_cyc(4);
        chk("hold_once", o_sec, 1);
        sec_drv = 1'b1;
        min_drv = 1'b1;
        ahour_drv = 1'b1;
        wait_cyc(5);
        sec_drv = 1'b0;
        min_drv = 1'b0;
        ahour_drv = 1'b0;
        wait_cyc(3);
        chk("simul_sec", o_sec, 2);
        chk("simul_min", o_min, 1);
        chk("simul_ahour", o_alarm_hour, 1);
        chk("simul_hour", o_hour, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
